shift_seq_reg: RTL and testbench
================================

# shift_seq_reg

Parametrised universal shift register with a multi-step shift sequencer. A single `start` command shifts or rotates the register left or right by 0..WIDTH positions, one bit per clock. Completion is signalled with `busy`/`done`. It replaces the fixed 8-bit left/right shifter in serial-conversion and bit-alignment datapaths, and adds parallel load, rotate, a serial output and programmable shift counts.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, $clog2(WIDTH+1), width of `amount` (derived; do not override)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  parallel load request (sampled only in IDLE)
- d  in  WIDTH  parallel load data
- start  in  1  shift command (sampled only in IDLE)
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB); latched at `start`
- rotate  in  1  1 = rotate, 0 = logical shift with `serial_in` fill; latched at `start`
- amount  in  AMT_W  number of single-bit steps; latched at `start`
- serial_in  in  1  fill bit, sampled on every shift edge
- q  out  WIDTH  register contents
- serial_out  out  1  bit expelled (or wrapped) at the most recent shift edge
- busy  out  1  shift sequence in progress
- done  out  1  one-cycle pulse on sequence completion

## Operation
- States: IDLE, SHIFT.
- IDLE, load=1: q <= d. load has priority over start; a simultaneous start is dropped. No done pulse.
- IDLE, start=1, amount=0: q unchanged; done=1 for one cycle; stay IDLE.
- IDLE, start=1, amount=N≥1:
  - Latch dir and rotate.
  - Latch count = min(N, WIDTH); any amount > WIDTH clamps to WIDTH.
  - Go to SHIFT.
- SHIFT, one step per edge:
  - Left: q <= {q[WIDTH-2:0], fill}; serial_out <= q[WIDTH-1].
  - Right: q <= {fill, q[WIDTH-1:1]}; serial_out <= q[0].
  - fill = the expelled bit when rotate=1, otherwise serial_in.
  - count decrements each step. On the step where count reaches 0: go to IDLE and set done=1 for the next cycle.
- load and start while busy are ignored; they are neither queued nor allowed to abort the sequence.
- dir/rotate changes during SHIFT have no effect; serial_in changes take effect on the next step.
- serial_out holds its value in IDLE and across load.

## Timing
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-sequence): q=0, serial_out=0, busy=0, done=0, state IDLE, count=0.
- Release of rst_n is synchronous to clk; the first command is accepted on the first rising edge after release.
- start accepted at edge E0 with N≥1:
  - busy=1 from after E0 until after EN.
  - Shifts occur on edges E1..EN.
  - After EN: busy=0, done=1 for exactly one cycle, q holds the final value.
- The next command is accepted at edge EN+1 (the cycle in which done=1). Back-to-back sequences therefore have a one-cycle gap.
- amount=0: done=1 in the cycle after E0; busy stays 0.
- load latency: q shows d one cycle after the sampling edge.
- busy and done are never high in the same cycle.

## Configuration
- SHREG_ROTATE_EN defined: `rotate` behaves as specified.
- SHREG_ROTATE_EN undefined:
  - The rotate path is not built and the `rotate` port is present but ignored.
  - Every step is a logical shift filled from serial_in.
  - serial_out still reports the expelled bit.

## Test plan
- Assert rst_n=0 with all inputs toggling -> q=8'h00, serial_out=0, busy=0, done=0 immediately. Release -> load d=8'h3C on the first edge gives q=8'h3C.
- WIDTH=8: load 8'hA5; start dir=0 rotate=0 amount=3 serial_in=0 -> busy high for 3 cycles, q steps 8'h4A, 8'h94, 8'h28; serial_out ends at 1; single done pulse.
- With SHREG_ROTATE_EN: load 8'h81; start dir=1 rotate=1 amount=1 -> q=8'hC0, serial_out=1. Without the macro, same stimulus with serial_in=0 -> q=8'h40.
- Load 8'hFF; start dir=1 amount=12 serial_in=0 -> clamps to 8 steps, busy exactly 8 cycles, q=8'h00.
- During busy, pulse load (d=8'h55) and start -> both ignored, sequence completes unchanged. In IDLE, load and start together -> q=d, no done pulse. amount=0 -> done next cycle, q unchanged.
- Drop rst_n after the 2nd step of a 5-step shift -> q=0 and busy=0 at once, no done pulse. After release, a new load/start sequence behaves normally.

Source files
------------

// File: rtl/shift_seq_reg.sv
// Universal shift register with a multi-step shift/rotate sequencer (one bit per clock).
// Optional rotate support is built only when SHREG_ROTATE_EN is defined.
module shift_seq_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic             dir,
    input  logic             rotate,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [AMT_W-1:0] MAX_CNT = AMT_W'(WIDTH);

    state_t           state;
    logic [AMT_W-1:0] count;
    logic             dir_r;
    logic             expelled;
    logic             fill;
    logic [WIDTH-1:0] shifted;

`ifdef SHREG_ROTATE_EN
    logic             rot_r;
`else
    logic             unused_rotate;
    assign unused_rotate = rotate;
`endif

    // NOTE: every output of an always_comb is given a value on every path, so no latch is inferred.
    always_comb begin
        expelled = dir_r ? q[0] : q[WIDTH-1];
`ifdef SHREG_ROTATE_EN
        fill = rot_r ? expelled : serial_in;
`else
        fill = serial_in;
`endif
        shifted = dir_r ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};
    end

    // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= '0;
            dir_r      <= 1'b0;
`ifdef SHREG_ROTATE_EN
            rot_r      <= 1'b0;
`endif
            q          <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        q <= d;
                    end else if (start) begin
                        if (amount == '0) begin
                            done <= 1'b1;
                        end else begin
                            dir_r <= dir;
`ifdef SHREG_ROTATE_EN
                            rot_r <= rotate;
`endif
                            // Requests longer than the register are clamped to a full pass.
                            count <= (amount > MAX_CNT) ? MAX_CNT : amount;
                            busy  <= 1'b1;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    q          <= shifted;
                    serial_out <= expelled;
                    count      <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_reg.sv
// Randomized self-checking bench for shift_seq_reg against a transaction-level model.
// Expected rotate behaviour follows SHREG_ROTATE_EN, matching the build of the design.
module tb_shift_seq_reg;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic             dir;
    logic             rotate;
    logic [AMT_W-1:0] amount;
    logic             serial_in;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] mq;
    logic             mso;

    shift_seq_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .d          (d),
        .start      (start),
        .dir        (dir),
        .rotate     (rotate),
        .amount     (amount),
        .serial_in  (serial_in),
        .q          (q),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rot_enabled(input bit r);
`ifdef SHREG_ROTATE_EN
        return r;
`else
        return 1'b0;
`endif
    endfunction

    task automatic randomize_ctrl();
        dir    = 1'($urandom_range(0, 1));
        rotate = 1'($urandom_range(0, 1));
        amount = AMT_W'($urandom_range(0, 15));
        d      = WIDTH'($urandom_range(0, 255));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic do_load(input logic [WIDTH-1:0] val, input bit with_start);
        randomize_ctrl();
        load  = 1'b1;
        d     = val;
        start = with_start;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        mq    = val;
        check("load_q", 32'(q), 32'(mq));
        check("load_so", 32'(serial_out), 32'(mso));
        check("load_busy", 32'(busy), 0);
        check("load_done", 32'(done), 0);
    endtask

    task automatic run_shift(input bit dr, input bit rt, input int amt, input bit rand_si, input bit inject);
        int n;
        bit out_bit;
        bit f;
        n = (amt > WIDTH) ? WIDTH : amt;
        load   = 1'b0;
        dir    = dr;
        rotate = rt;
        amount = AMT_W'(amt);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        randomize_ctrl();
        if (n == 0) begin
            check("zero_done", 32'(done), 1);
            check("zero_busy", 32'(busy), 0);
            check("zero_q", 32'(q), 32'(mq));
        end
        for (int k = 1; k <= n; k++) begin
            check("step_busy", 32'(busy), 1);
            check("step_done", 32'(done), 0);
            serial_in = rand_si ? 1'($urandom_range(0, 1)) : 1'b0;
            if (inject && k == 2) begin
                load  = 1'b1;
                d     = 8'h55;
                start = 1'b1;
            end
            out_bit = dr ? mq[0] : mq[WIDTH-1];
            f = rot_enabled(rt) ? out_bit : serial_in;
            if (dr)
                mq = (mq >> 1) | (WIDTH'(f) << (WIDTH - 1));
            else
                mq = (mq << 1) | WIDTH'(f);
            mso = out_bit;
            @(posedge clk);
            #1;
            load  = 1'b0;
            start = 1'b0;
            randomize_ctrl();
            check("step_q", 32'(q), 32'(mq));
            check("step_so", 32'(serial_out), 32'(mso));
        end
        if (n > 0) begin
            check("end_busy", 32'(busy), 0);
            check("end_done", 32'(done), 1);
        end
        @(posedge clk);
        #1;
        check("done_clear", 32'(done), 0);
        check("idle_q", 32'(q), 32'(mq));
        check("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        load = 1'b0; start = 1'b0; dir = 1'b0; rotate = 1'b0;
        amount = '0; serial_in = 1'b0; d = '0;
        mq = '0; mso = 1'b0;
        #1 rst_n = 1'b0;
        // Inputs toggle freely while reset is held.
        for (int i = 0; i < 4; i++) begin
            randomize_ctrl();
            load = 1'b1; start = 1'b1; serial_in = 1'($urandom_range(0, 1));
            #4;
            check("rst_q", 32'(q), 0);
            check("rst_so", 32'(serial_out), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
        end
        load = 1'b0; start = 1'b0; serial_in = 1'b0;
        #5 rst_n = 1'b1;
        do_load(8'h3C, 1'b0);

        do_load(8'hA5, 1'b0);
        run_shift(1'b0, 1'b0, 3, 1'b0, 1'b0);
        check("a5_q", 32'(q), 32'h28);
        check("a5_so", 32'(serial_out), 1);

        do_load(8'h81, 1'b0);
        run_shift(1'b1, 1'b1, 1, 1'b0, 1'b0);
`ifdef SHREG_ROTATE_EN
        check("rot_q", 32'(q), 32'hC0);
`else
        check("rot_q", 32'(q), 32'h40);
`endif
        check("rot_so", 32'(serial_out), 1);

        do_load(8'hFF, 1'b0);
        run_shift(1'b1, 1'b0, 12, 1'b0, 1'b0);
        check("clamp_q", 32'(q), 0);

        do_load(8'h96, 1'b0);
        run_shift(1'b0, 1'b1, 6, 1'b1, 1'b1);

        do_load(8'h5A, 1'b1);
        @(posedge clk);
        #1;
        check("ld_st_done", 32'(done), 0);
        check("ld_st_busy", 32'(busy), 0);

        run_shift(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Reset in the middle of a 5-step sequence, after its second step.
        do_load(8'hB7, 1'b0);
        dir = 1'b0; rotate = 1'b0; amount = AMT_W'(5); serial_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mq = '0; mso = 1'b0;
        check("mid_rst_q", 32'(q), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_so", 32'(serial_out), 0);
        randomize_ctrl();
        start = 1'b1; load = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_hold_busy", 32'(busy), 0);
        check("mid_rst_hold_done", 32'(done), 0);
        start = 1'b0; load = 1'b0;
        #2 rst_n = 1'b1;
        do_load(8'hC3, 1'b0);
        run_shift(1'b1, 1'b0, 4, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_load(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            run_shift(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 15)), 1'b1, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
